// File: rtl/udma_i2c_ch_arb.sv
// udma_i2c_ch_arb: lets NB_CH uDMA channel pairs share one I2C controller.
// Ownership is granted round-robin for each transaction. The owner's TX stream
// passes straight through to the controller, and controller RX bytes are routed
// back to the owner.
// The optional watchdog is enabled with `define UDMA_I2C_ARB_TIMEOUT_EN.
// When it is enabled, the timeout_cycles_i port exists and a stalled XFER is
// forced into WAIT_DONE.
module udma_i2c_ch_arb #(
    parameter int NB_CH    = 4,
    parameter int TO_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NB_CH*8-1:0]       ch_tx_data_i,
    input  logic [NB_CH-1:0]         ch_tx_valid_i,
    input  logic [NB_CH-1:0]         ch_tx_last_i,
    output logic [NB_CH-1:0]         ch_tx_ready_o,
    output logic [NB_CH*8-1:0]       ch_rx_data_o,
    output logic [NB_CH-1:0]         ch_rx_valid_o,
    input  logic [NB_CH-1:0]         ch_rx_ready_i,
    output logic [7:0]               ctrl_tx_data_o,
    output logic                     ctrl_tx_valid_o,
    input  logic                     ctrl_tx_ready_i,
    input  logic [7:0]               ctrl_rx_data_i,
    input  logic                     ctrl_rx_valid_i,
    output logic                     ctrl_rx_ready_o,
    input  logic                     ctrl_busy_i,
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
    input  logic [TO_WIDTH-1:0]      timeout_cycles_i,
`endif
    output logic [$clog2(NB_CH)-1:0] owner_o,
    output logic                     owner_valid_o,
    output logic                     err_o
);

    localparam int OW = $clog2(NB_CH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        XFER      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            err_q, err_d;

    logic [7:0]      tx_bytes [NB_CH];
    logic            in_xfer;
    logic            tx_hs;
    logic            arb_found;
    logic [OW-1:0]   arb_winner;
    logic            timeout_hit;

    assign in_xfer = (state_q == XFER);

    // Slice the flat channel data bus into bytes, and build the per-channel ready and RX lanes.
    for (genvar gi = 0; gi < NB_CH; gi++) begin : g_lane
        logic is_owner;
        assign is_owner                 = (owner_q == OW'(gi));
        assign tx_bytes[gi]             = ch_tx_data_i[gi*8 +: 8];
        assign ch_tx_ready_o[gi]        = in_xfer && is_owner && ctrl_tx_ready_i;
        assign ch_rx_valid_o[gi]        = (state_q != IDLE) && is_owner && ctrl_rx_valid_i;
        assign ch_rx_data_o[gi*8 +: 8]  = ((state_q != IDLE) && is_owner) ? ctrl_rx_data_i : 8'h00;
    end

    assign ctrl_tx_valid_o = in_xfer && ch_tx_valid_i[owner_q];
    assign ctrl_tx_data_o  = in_xfer ? tx_bytes[owner_q] : 8'h00;
    assign tx_hs           = ctrl_tx_valid_o && ctrl_tx_ready_i;
    // In IDLE nobody owns RX, so stray bytes are accepted and discarded.
    assign ctrl_rx_ready_o = (state_q == IDLE) ? 1'b1 : ch_rx_ready_i[owner_q];

    assign owner_o       = owner_q;
    assign owner_valid_o = (state_q != IDLE);
    assign err_o         = err_q;

    // Round-robin search: the first valid channel above rr_ptr, wrapping around.
    always_comb begin
        int idx;
        arb_found  = 1'b0;
        arb_winner = '0;
        idx        = 0;
        for (int i = 1; i <= NB_CH; i++) begin
            idx = (int'(rr_ptr_q) + i) % NB_CH;
            if (!arb_found && ch_tx_valid_i[idx]) begin
                arb_found  = 1'b1;
                arb_winner = OW'(idx);
            end
        end
    end

`ifdef UDMA_I2C_ARB_TIMEOUT_EN
    logic [TO_WIDTH-1:0] wdog_q, wdog_d;

    // Count XFER cycles since the last TX handshake; a zero threshold disables the watchdog.
    always_comb begin
        wdog_d      = '0;
        timeout_hit = 1'b0;
        if (in_xfer && !tx_hs) begin
            wdog_d = wdog_q + 1'b1;
            if ((timeout_cycles_i != '0) && (wdog_d >= timeout_cycles_i)) begin
                timeout_hit = 1'b1;
                wdog_d      = '0;
            end
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic: arbitrate in IDLE, pass through in XFER, release once the controller is idle.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = ctrl_rx_valid_i;
                if (arb_found) begin
                    owner_d = arb_winner;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (tx_hs && ch_tx_last_i[owner_q]) begin
                    state_d = WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d = WAIT_DONE;
                    err_d   = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!ctrl_busy_i) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, owner, round-robin pointer and error pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= OW'(NB_CH - 1);
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_udma_i2c_ch_arb.sv
// Self-checking bench for udma_i2c_ch_arb.
// A behavioural model is checked against the DUT on every cycle. Directed
// scenarios add literal expectations. The timeout scenario depends on
// UDMA_I2C_ARB_TIMEOUT_EN.
module tb_udma_i2c_ch_arb;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB*8-1:0] tx_data;
    logic [NB-1:0] tx_v, tx_last, tx_rdy;
    logic [NB*8-1:0] rx_data_o;
    logic [NB-1:0] rx_v_o, rx_rdy;
    logic [7:0]    c_tx_data;
    logic          c_tx_valid, c_tx_ready;
    logic [7:0]    c_rx_data;
    logic          c_rx_valid, c_rx_ready, busy;
    logic [15:0]   to_cycles;
    logic [1:0]    owner;
    logic          owner_valid, err;

    always #5 clk = ~clk;

    udma_i2c_ch_arb #(.NB_CH(NB), .TO_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .ch_tx_data_i(tx_data), .ch_tx_valid_i(tx_v), .ch_tx_last_i(tx_last),
        .ch_tx_ready_o(tx_rdy),
        .ch_rx_data_o(rx_data_o), .ch_rx_valid_o(rx_v_o), .ch_rx_ready_i(rx_rdy),
        .ctrl_tx_data_o(c_tx_data), .ctrl_tx_valid_o(c_tx_valid), .ctrl_tx_ready_i(c_tx_ready),
        .ctrl_rx_data_i(c_rx_data), .ctrl_rx_valid_i(c_rx_valid), .ctrl_rx_ready_o(c_rx_ready),
        .ctrl_busy_i(busy),
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
        .timeout_cycles_i(to_cycles),
`endif
        .owner_o(owner), .owner_valid_o(owner_valid), .err_o(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 = idle, 1 = transferring, 2 = waiting for the controller.
    int m_st  = 0;
    int m_own = 0;
    int m_rr  = NB - 1;
    bit m_err = 1'b0;
    int m_wd  = 0;
    int m_w;
    bit m_hs;
    bit chk_en = 1'b0;

    function automatic int next_winner(input logic [NB-1:0] v, input int rr);
        for (int k = 1; k <= NB; k++) begin
            if (v[(rr + k) % NB]) return (rr + k) % NB;
        end
        return -1;
    endfunction

    always_comb begin
        m_w  = next_winner(tx_v, m_rr);
        m_hs = (m_st == 1) && tx_v[m_own] && c_tx_ready;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_st <= 0; m_own <= 0; m_rr <= NB - 1; m_err <= 1'b0; m_wd <= 0;
        end else begin
            m_err <= 1'b0;
            m_wd  <= 0;
            if (m_st == 0) begin
                if (c_rx_valid) m_err <= 1'b1;
                if (m_w >= 0) begin m_own <= m_w; m_st <= 1; end
            end else if (m_st == 1) begin
                if (m_hs && tx_last[m_own]) m_st <= 2;
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
                else if (!m_hs && to_cycles != 0 && m_wd + 1 >= int'(to_cycles)) begin
                    m_st <= 2; m_err <= 1'b1;
                end else if (!m_hs) m_wd <= m_wd + 1;
`endif
            end else begin
                if (!busy) begin m_st <= 0; m_rr <= m_own; end
            end
        end
    end

    // Compare every DUT output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ch_tx_ready", 32'(tx_rdy), (m_st == 1 && c_tx_ready) ? (32'd1 << m_own) : 32'd0);
            chk("ctrl_tx_valid", 32'(c_tx_valid), 32'(m_st == 1 && tx_v[m_own]));
            if (m_st == 1 && tx_v[m_own]) chk("ctrl_tx_data", 32'(c_tx_data), 32'(tx_data[m_own*8 +: 8]));
            chk("owner_valid", 32'(owner_valid), 32'(m_st != 0));
            if (m_st != 0) chk("owner", 32'(owner), 32'(m_own));
            chk("ctrl_rx_ready", 32'(c_rx_ready), (m_st == 0) ? 32'd1 : 32'(rx_rdy[m_own]));
            chk("ch_rx_valid", 32'(rx_v_o), (m_st != 0 && c_rx_valid) ? (32'd1 << m_own) : 32'd0);
            if (m_st != 0 && c_rx_valid) chk("ch_rx_data", 32'(rx_data_o[m_own*8 +: 8]), 32'(c_rx_data));
            chk("err", 32'(err), 32'(m_err));
        end
    end

    // Grant log and error pulse counter.
    int  grants[$];
    int  err_cnt = 0;
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        prev_ov <= owner_valid;
        if (owner_valid && !prev_ov) grants.push_back(int'(owner));
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tx_v = '0; tx_last = '0; c_tx_ready = 1'b0; c_rx_valid = 1'b0;
        c_rx_data = 8'h00; rx_rdy = '1; busy = 1'b0; to_cycles = 16'd0;
        tx_data = 32'h13121110;
        cyc(2);
        rst = 1'b0;
        grants.delete();
    endtask

    task automatic chk_grants(input string name, input int exp0, input int exp1);
        chk({name, "_count"}, 32'(grants.size() >= 2), 32'd1);
        if (grants.size() >= 2) begin
            chk({name, "_g0"}, 32'(grants[0]), 32'(exp0));
            chk({name, "_g1"}, 32'(grants[1]), 32'(exp1));
        end
    endtask

    int e0;

    initial begin
        // Reset state
        rst = 1'b1; tx_v = '0; tx_last = '0; c_tx_ready = 1'b0; c_rx_valid = 1'b0;
        c_rx_data = 8'h00; rx_rdy = '1; busy = 1'b0; to_cycles = 16'd0; tx_data = 32'h13121110;
        cyc(2);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_owner_valid", 32'(owner_valid), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ctrl_rx_ready", 32'(c_rx_ready), 32'd1);
        chk("rst_ch_tx_ready", 32'(tx_rdy), 32'd0);
        chk("rst_ctrl_tx_valid", 32'(c_tx_valid), 32'd0);
        chk("rst_ch_rx_valid", 32'(rx_v_o), 32'd0);
        cyc(1);
        rst = 1'b0;
        $display("txn reset: outputs checked");

        // ch0 and ch2 together: ch0 first with one cycle of latency, then ch2
        do_reset();
        busy = 1'b1; c_tx_ready = 1'b1; tx_v = 4'b0101; tx_last = 4'b0101;
        @(negedge clk);
        chk("g027_idle", 32'(owner_valid), 32'd0);
        cyc(1);
        @(negedge clk);
        chk("g027_lat_valid", 32'(owner_valid), 32'd1);
        chk("g027_lat_owner", 32'(owner), 32'd0);
        cyc(1);
        tx_v = 4'b0100;
        cyc(3);
        busy = 1'b0;
        cyc(6);
        chk_grants("g027", 0, 2);
        tx_v = '0;
        cyc(4);
        $display("txn ch0+ch2 arbitration: %0d grants logged", grants.size());

        // All channels continuously valid with single-byte transactions
        do_reset();
        c_tx_ready = 1'b1; tx_v = 4'b1111; tx_last = 4'b1111;
        cyc(16);
        chk("g028_count", 32'(grants.size() >= 5), 32'd1);
        if (grants.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("g028_order", 32'(grants[i]), 32'(i % 4));
        end
        tx_v = '0;
        cyc(4);
        $display("txn round-robin: %0d grants logged", grants.size());

        // ch1 owns the controller while ctrl_tx_ready_i stalls; other channels are held
        do_reset();
        busy = 1'b1; c_tx_ready = 1'b0; tx_data = 32'h1311A510; tx_v = 4'b0010; tx_last = 4'b0000;
        cyc(1);
        tx_v = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("g029_data", 32'(c_tx_data), 32'hA5);
            chk("g029_ready", 32'(tx_rdy), 32'd0);
            chk("g029_valid", 32'(c_tx_valid), 32'd1);
            cyc(1);
        end
        c_tx_ready = 1'b1; tx_last = 4'b0010;
        @(negedge clk);
        chk("g029_release_ready", 32'(tx_rdy), 32'b0010);
        cyc(1);
        tx_v = 4'b1001; tx_last = 4'b0000; busy = 1'b0;
        cyc(4);
        chk_grants("g029", 1, 3);
        $display("txn ch1 stall: %0d grants logged", grants.size());

        // RX routed to owner 3 in WAIT_DONE, then dropped with an error pulse in IDLE
        do_reset();
        busy = 1'b1; c_tx_ready = 1'b1; tx_v = 4'b1000; tx_last = 4'b1000;
        cyc(2);
        tx_v = '0; c_rx_valid = 1'b1; c_rx_data = 8'h5A;
        @(negedge clk);
        chk("g030_rx_data", 32'(rx_data_o[31:24]), 32'h5A);
        chk("g030_rx_valid", 32'(rx_v_o), 32'b1000);
        cyc(1);
        c_rx_valid = 1'b0; busy = 1'b0;
        cyc(1);
        e0 = err_cnt;
        c_rx_valid = 1'b1;
        @(negedge clk);
        chk("g030_idle_rx_valid", 32'(rx_v_o), 32'd0);
        chk("g030_idle_rx_ready", 32'(c_rx_ready), 32'd1);
        chk("g030_idle_err_before", 32'(err), 32'd0);
        cyc(1);
        c_rx_valid = 1'b0;
        @(negedge clk);
        chk("g030_err_pulse", 32'(err), 32'd1);
        cyc(1);
        @(negedge clk);
        chk("g030_err_cleared", 32'(err), 32'd0);
        cyc(1);
        chk("g030_err_count", 32'(err_cnt - e0), 32'd1);
        $display("txn rx routing: err pulses %0d", err_cnt - e0);

        // Owner goes silent mid-transaction
        do_reset();
        busy = 1'b1; c_tx_ready = 1'b1; to_cycles = 16'd10; tx_v = 4'b0001; tx_last = 4'b0000;
        cyc(1);
        tx_v = '0;
        e0 = err_cnt;
        cyc(20);
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
        chk("g031_err_count", 32'(err_cnt - e0), 32'd1);
        @(negedge clk);
        chk("g031_still_owned", 32'(owner_valid), 32'd1);
        cyc(1);
        busy = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("g031_released", 32'(owner_valid), 32'd0);
`else
        chk("g031_no_err", 32'(err_cnt - e0), 32'd0);
        @(negedge clk);
        chk("g031_still_owned", 32'(owner_valid), 32'd1);
`endif
        cyc(1);
        $display("txn silent owner: err pulses %0d", err_cnt - e0);

        // Reset pulse mid-XFER: release immediately, then ch0 wins
        do_reset();
        busy = 1'b1; c_tx_ready = 1'b1; tx_v = 4'b0100; tx_last = 4'b0000;
        cyc(3);
        rst = 1'b1; tx_v = 4'b0101;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        chk("g032_released", 32'(owner_valid), 32'd0);
        chk("g032_no_tx", 32'(c_tx_valid), 32'd0);
        cyc(1);
        @(negedge clk);
        chk("g032_regrant_valid", 32'(owner_valid), 32'd1);
        chk("g032_regrant_owner", 32'(owner), 32'd0);
        cyc(2);
        $display("txn reset mid-xfer: owner %0d", owner);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
